vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator. It is the successor to the fixed 640x480@60 display block.
- Derives a pixel-enable from the system clock by an integer divider.
- Runs horizontal and vertical counters with fully parametrised porch and sync widths and programmable sync polarity.
- Drives registered sync, data-enable, pixel coordinates and COLOR_BITS-wide RGB.
- Selects one of four test patterns, including an animated bouncing box.

---
 rtl/vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with four selectable test patterns.
// Every output is registered from the (hcount, vcount) seen on a pixel-enable cycle.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int BOX_SIZE   = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [10:0]           xpos,
  output logic [10:0]           ypos,
  output logic [COLOR_BITS-1:0] disp_R,
  output logic [COLOR_BITS-1:0] disp_G,
  output logic [COLOR_BITS-1:0] disp_B,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE    = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_EDGE_LO   = 11'(EDGE);
  localparam logic [10:0] V_EDGE_LO   = 11'(EDGE);
  localparam logic [10:0] H_EDGE_HI   = 11'(H_ACTIVE - EDGE);
  localparam logic [10:0] V_EDGE_HI   = 11'(V_ACTIVE - EDGE);

  localparam logic [COLOR_BITS-1:0] C_FULL = '1;
  localparam logic [COLOR_BITS-1:0] C_GREY = C_FULL ^ (C_FULL >> 1);

  // Timing state
  logic [DIV_W-1:0] div_reg;
  logic [10:0]      hcount_reg;
  logic [10:0]      vcount_reg;
  logic [1:0]       mode_reg;

  // Bouncing box, axis 0 = x, axis 1 = y; dir bit 1 means moving towards +
  logic [1:0][10:0] box_pos_reg;
  logic [1:0][10:0] box_pos_next;
  logic [1:0]       box_dir_reg;
  logic [1:0]       box_dir_next;

  // Output registers
  logic                  hsync_reg;
  logic                  vsync_reg;
  logic                  de_reg;
  logic [10:0]           xpos_reg;
  logic [10:0]           ypos_reg;
  logic [COLOR_BITS-1:0] r_reg;
  logic [COLOR_BITS-1:0] g_reg;
  logic [COLOR_BITS-1:0] b_reg;
  logic                  frame_start_reg;

  logic                  pe;
  logic                  h_wrap;
  logic                  v_wrap;
  logic                  frame_pe;
  logic [1:0]            mode_cur;
  logic                  h_vis;
  logic                  v_vis;
  logic                  vis;
  logic [10:0]           x_off;
  logic [10:0]           y_off;
  logic [1:0][10:0]      coord;
  logic                  near_edge;
  logic [6:0]            bar_ge;
  logic [2:0]            bar_idx;
  logic [1:0]            in_box;
  logic                  hsync_next;
  logic                  vsync_next;
  logic [10:0]           xpos_next;
  logic [10:0]           ypos_next;
  logic [COLOR_BITS-1:0] r_next;
  logic [COLOR_BITS-1:0] g_next;
  logic [COLOR_BITS-1:0] b_next;

  assign pe       = (div_reg == DIV_LAST);
  assign h_wrap   = (hcount_reg == H_LAST);
  assign v_wrap   = (vcount_reg == V_LAST);
  assign frame_pe = pe && (hcount_reg == 11'd0) && (vcount_reg == 11'd0);
  // The mode captured at frame start already governs pixel (0,0).
  assign mode_cur = frame_pe ? mode : mode_reg;

  assign h_vis = (hcount_reg >= H_ACT_START) && (hcount_reg < H_ACT_END);
  assign v_vis = (vcount_reg >= V_ACT_START) && (vcount_reg < V_ACT_END);
  assign vis   = h_vis && v_vis;
  assign x_off = hcount_reg - H_ACT_START;
  assign y_off = vcount_reg - V_ACT_START;
  assign coord = {y_off, x_off};

  assign hsync_next = (hcount_reg < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_next = (vcount_reg < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
  assign xpos_next  = vis ? x_off : 11'd0;
  assign ypos_next  = vis ? y_off : 11'd0;

  assign near_edge = (x_off < H_EDGE_LO) || (x_off >= H_EDGE_HI) ||
                     (y_off < V_EDGE_LO) || (y_off >= V_EDGE_HI);

  // Bar index = number of thresholds k*H_ACTIVE/8 that xpos has reached.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bar
      localparam logic [13:0] BAR_THR = 14'((gi + 1) * H_ACTIVE);
      assign bar_ge[gi] = ({x_off, 3'b000} >= BAR_THR);
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      bar_idx = bar_idx + 3'(bar_ge[k]);
    end
  end

  // Per-axis box motion and coverage test; reversal happens on the limit frame itself.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_box
      localparam logic [10:0] LIMIT = (gi == 0) ? 11'(H_ACTIVE - BOX_SIZE)
                                                : 11'(V_ACTIVE - BOX_SIZE);
      logic at_turn;
      assign at_turn = box_dir_reg[gi] ? (box_pos_reg[gi] == LIMIT)
                                       : (box_pos_reg[gi] == 11'd0);
      assign box_dir_next[gi] = at_turn ? ~box_dir_reg[gi] : box_dir_reg[gi];
      assign box_pos_next[gi] = box_dir_next[gi] ? box_pos_reg[gi] + 11'd1
                                                 : box_pos_reg[gi] - 11'd1;
      assign in_box[gi] = (coord[gi] >= box_pos_reg[gi]) &&
                          ({1'b0, coord[gi]} < ({1'b0, box_pos_reg[gi]} + 12'(BOX_SIZE)));
    end
  endgenerate

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (vis) begin
      case (mode_cur)
        2'd0: begin
          if (near_edge) b_next = C_FULL;
          else           r_next = C_FULL;
        end
        2'd1: begin
          r_next = bar_idx[2] ? C_FULL : '0;
          g_next = bar_idx[1] ? C_FULL : '0;
          b_next = bar_idx[0] ? C_FULL : '0;
        end
        2'd2: begin
          if (&in_box) begin
            r_next = C_FULL;
            g_next = C_FULL;
            b_next = C_FULL;
          end
        end
        default: begin
          r_next = C_GREY;
          g_next = C_GREY;
          b_next = C_GREY;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_reg     <= '0;
      hcount_reg  <= 11'd0;
      vcount_reg  <= 11'd0;
      mode_reg    <= 2'd0;
      box_pos_reg <= '0;
      box_dir_reg <= 2'b11;
    end else begin
      div_reg <= pe ? '0 : div_reg + 1'b1;
      if (pe) begin
        hcount_reg <= h_wrap ? 11'd0 : hcount_reg + 11'd1;
        if (h_wrap) vcount_reg <= v_wrap ? 11'd0 : vcount_reg + 11'd1;
      end
      if (frame_pe) begin
        mode_reg    <= mode;
        box_pos_reg <= box_pos_next;
        box_dir_reg <= box_dir_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      de_reg          <= 1'b0;
      xpos_reg        <= 11'd0;
      ypos_reg        <= 11'd0;
      r_reg           <= '0;
      g_reg           <= '0;
      b_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_pe;
      if (pe) begin
        hsync_reg <= hsync_next;
        vsync_reg <= vsync_next;
        de_reg    <= vis;
        xpos_reg  <= xpos_next;
        ypos_reg  <= ypos_next;
        r_reg     <= r_next;
        g_reg     <= g_next;
        b_reg     <= b_next;
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign xpos        = xpos_reg;
  assign ypos        = ypos_reg;
  assign disp_R      = r_reg;
  assign disp_G      = g_reg;
  assign disp_B      = b_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: a clock-by-clock reference model
// plus a table of hand-computed pixel colours and timing measurements.
module tb_vga_timing_gen;

  localparam int CLK_DIV    = 2;
  localparam int H_SYNC     = 4;
  localparam int H_BP       = 3;
  localparam int H_ACTIVE   = 24;
  localparam int H_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 2;
  localparam int V_ACTIVE   = 20;
  localparam int V_FP       = 2;
  localparam bit HSYNC_POL  = 1'b1;
  localparam bit VSYNC_POL  = 1'b0;
  localparam int COLOR_BITS = 4;
  localparam int BOX_SIZE   = 4;

  localparam int HT         = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT         = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FRAME      = HT * VT;
  localparam int FRAME_CLKS = FRAME * CLK_DIV;
  localparam logic [3:0] F  = 4'hF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] xpos, ypos;
  logic [3:0]  disp_R, disp_G, disp_B;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .COLOR_BITS(COLOR_BITS),
    .BOX_SIZE(BOX_SIZE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de), .xpos(xpos), .ypos(ypos),
    .disp_R(disp_R), .disp_G(disp_G), .disp_B(disp_B), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        fs;
  } obs_t;

  typedef struct {
    logic [1:0] md;
    int         x;
    int         y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         n = 0;            // clock edges since reset release
  logic [1:0] frame_mode = 2'd0;
  vec_t       tbl[16];

  // Box position after k frame starts: triangle wave between 0 and m.
  function automatic int tri_pos(int k, int m);
    int t;
    t = k % (2 * m);
    return (t <= m) ? t : 2 * m - t;
  endfunction

  function automatic obs_t pixel_out(int p, logic [1:0] md);
    obs_t o;
    int h, v, f, x, y, bi, bxp, byp;
    o  = '0;
    h  = p % HT;
    v  = (p / HT) % VT;
    f  = p / FRAME;
    o.hs = (h < H_SYNC) ? HSYNC_POL : !HSYNC_POL;
    o.vs = (v < V_SYNC) ? VSYNC_POL : !VSYNC_POL;
    o.de = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
           (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
    if (o.de) begin
      x = h - (H_SYNC + H_BP);
      y = v - (V_SYNC + V_BP);
      o.x = 11'(x);
      o.y = 11'(y);
      case (md)
        2'd0: begin
          if (x < 8 || x >= H_ACTIVE - 8 || y < 8 || y >= V_ACTIVE - 8) o.b = F;
          else o.r = F;
        end
        2'd1: begin
          bi = x * 8 / H_ACTIVE;
          o.r = ((bi & 4) != 0) ? F : 4'h0;
          o.g = ((bi & 2) != 0) ? F : 4'h0;
          o.b = ((bi & 1) != 0) ? F : 4'h0;
        end
        2'd2: begin
          bxp = tri_pos(f + 1, H_ACTIVE - BOX_SIZE);
          byp = tri_pos(f + 1, V_ACTIVE - BOX_SIZE);
          if (x >= bxp && x < bxp + BOX_SIZE && y >= byp && y < byp + BOX_SIZE) begin
            o.r = F; o.g = F; o.b = F;
          end
        end
        default: begin
          o.r = 4'h8; o.g = 4'h8; o.b = 4'h8;
        end
      endcase
    end
    return o;
  endfunction

  function automatic obs_t expected_out();
    obs_t o;
    if (n < CLK_DIV) begin
      o    = '0;
      o.hs = !HSYNC_POL;
      o.vs = !VSYNC_POL;
    end else begin
      o    = pixel_out(n / CLK_DIV - 1, frame_mode);
      o.fs = (n % CLK_DIV == 0) && (((n / CLK_DIV - 1) % FRAME) == 0);
    end
    return o;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic       r_at;
    logic [1:0] m_at;
    obs_t       exp_o, act_o;
    r_at = reset_n;
    m_at = mode;
    @(posedge clock);
    #1;
    if (!r_at) begin
      n = 0;
      frame_mode = 2'd0;
    end else begin
      n++;
      if ((n % CLK_DIV == 0) && (((n / CLK_DIV - 1) % FRAME) == 0)) frame_mode = m_at;
    end
    exp_o = expected_out();
    act_o = {hsync, vsync, de, xpos, ypos, disp_R, disp_G, disp_B, frame_start};
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL model n=%0d got hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h%h%h fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h%h%h fs=%b",
               n, act_o.hs, act_o.vs, act_o.de, act_o.x, act_o.y, act_o.r, act_o.g, act_o.b, act_o.fs,
               exp_o.hs, exp_o.vs, exp_o.de, exp_o.x, exp_o.y, exp_o.r, exp_o.g, exp_o.b, exp_o.fs);
    end
  endtask

  task automatic wait_frame_start(string name);
    int k;
    k = 0;
    do begin step(); k++; end while (!frame_start && k < 2 * FRAME_CLKS);
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL %s frame_start timeout got none want pulse within %0d clocks", name, 2 * FRAME_CLKS);
    end
  endtask

  task automatic wait_pixel(int x, int y, logic [3:0] r, logic [3:0] g, logic [3:0] b, string name);
    int k;
    k = 0;
    do begin step(); k++; end
    while (!(de && xpos == 11'(x) && ypos == 11'(y)) && k < 2 * FRAME_CLKS);
    checks++;
    if (!(de && xpos == 11'(x) && ypos == 11'(y)) || disp_R !== r || disp_G !== g || disp_B !== b) begin
      errors++;
      $display("FAIL %s pixel(%0d,%0d) got de=%b rgb=%h%h%h want rgb=%h%h%h",
               name, x, y, de, disp_R, disp_G, disp_B, r, g, b);
    end
  endtask

  function automatic logic sig_active(int sel);
    case (sel)
      0:       return hsync == HSYNC_POL;
      1:       return vsync == VSYNC_POL;
      default: return de;
    endcase
  endfunction

  // Length in clocks of the next complete active run of the selected signal.
  task automatic measure_run(int sel, int exp_len, string name);
    int k, len;
    k = 0;
    len = 0;
    while (sig_active(sel) && k < 2 * FRAME_CLKS) begin step(); k++; end
    while (!sig_active(sel) && k < 2 * FRAME_CLKS) begin step(); k++; end
    while (sig_active(sel) && k < 2 * FRAME_CLKS) begin step(); k++; len++; end
    checks++;
    if (len != exp_len) begin
      errors++;
      $display("FAIL %s run length got %0d want %0d", name, len, exp_len);
    end
  endtask

  task automatic check_first_start(string name);
    int k;
    k = 0;
    do begin step(); k++; end while (!frame_start && k < 4 * CLK_DIV);
    checks++;
    if (!frame_start || k != CLK_DIV) begin
      errors++;
      $display("FAIL %s first frame_start got %0d clocks want %0d", name, k, CLK_DIV);
    end
  endtask

  task automatic measure_frame(string name);
    int len;
    len = 0;
    wait_frame_start(name);
    do begin step(); len++; end while (!frame_start && len < 2 * FRAME_CLKS);
    checks++;
    if (len != FRAME_CLKS) begin
      errors++;
      $display("FAIL %s frame period got %0d want %0d", name, len, FRAME_CLKS);
    end
  endtask

  initial begin
    int cur_md;
    int m;

    // Mode, x, y, expected R/G/B; entries within a mode are in raster order.
    tbl[0]  = '{2'd0,  0,  0, 4'h0, 4'h0, 4'hF};
    tbl[1]  = '{2'd0,  8,  8, 4'hF, 4'h0, 4'h0};
    tbl[2]  = '{2'd0,  7, 10, 4'h0, 4'h0, 4'hF};
    tbl[3]  = '{2'd0, 15, 11, 4'hF, 4'h0, 4'h0};
    tbl[4]  = '{2'd0, 16, 11, 4'h0, 4'h0, 4'hF};
    tbl[5]  = '{2'd0, 10, 12, 4'h0, 4'h0, 4'hF};
    tbl[6]  = '{2'd1,  0,  0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{2'd1,  2,  0, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{2'd1,  3,  0, 4'h0, 4'h0, 4'hF};
    tbl[9]  = '{2'd1,  6,  0, 4'h0, 4'hF, 4'h0};
    tbl[10] = '{2'd1, 11,  0, 4'h0, 4'hF, 4'hF};
    tbl[11] = '{2'd1, 12,  0, 4'hF, 4'h0, 4'h0};
    tbl[12] = '{2'd1, 20,  0, 4'hF, 4'hF, 4'h0};
    tbl[13] = '{2'd1, 23,  0, 4'hF, 4'hF, 4'hF};
    tbl[14] = '{2'd3,  5,  5, 4'h8, 4'h8, 4'h8};
    tbl[15] = '{2'd3, 23, 19, 4'h8, 4'h8, 4'h8};

    reset_n = 1'b0;
    mode    = 2'd0;
    for (int i = 0; i < 4; i++) step();

    reset_n = 1'b1;
    check_first_start("release");
    measure_frame("frame");
    measure_run(0, H_SYNC * CLK_DIV, "hsync");
    measure_run(1, V_SYNC * HT * CLK_DIV, "vsync");
    measure_run(2, H_ACTIVE * CLK_DIV, "de");

    cur_md = -1;
    for (int i = 0; i < 16; i++) begin
      if (int'(tbl[i].md) != cur_md) begin
        mode   = tbl[i].md;
        cur_md = int'(tbl[i].md);
        wait_frame_start("table");
      end
      wait_pixel(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b, "table");
    end

    // A mode change mid-frame must not alter the current frame.
    mode = 2'd0;
    wait_frame_start("midmode");
    wait_pixel(5, 10, 4'h0, 4'h0, 4'hF, "midmode_before");
    mode = 2'd3;
    wait_pixel(10, 11, 4'hF, 4'h0, 4'h0, "midmode_same_frame");
    wait_pixel(5, 5, 4'h8, 4'h8, 4'h8, "midmode_next_frame");

    // Random mode changes at random clocks, biased towards the bouncing box.
    for (int c = 0; c < 24 * FRAME_CLKS; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        m    = int'($urandom_range(0, 5));
        mode = (m > 3) ? 2'd2 : 2'(m);
      end
      step();
    end

    // One-clock reset pulse in the middle of a line.
    wait_frame_start("prereset");
    for (int i = 0; i < int'($urandom_range(80, 120)); i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_first_start("midline_reset");
    mode = 2'd2;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
